instruction_register: RTL and testbench

- Parameterised instruction register (IR) for the processor datapath.
- Captures an instruction word from the shared data bus when the control unit asserts a write enable.
- Holds that word and presents it continuously to the decoder / control unit.
- Also presents split opcode/operand fields and a valid flag for convenience.

---
 rtl/instruction_register.sv | 36 +++
 tb/tb_instruction_register.sv | 138 +++++++++++++
 2 files changed

// File: rtl/instruction_register.sv
// Instruction register: captures an instruction word from the shared bus
// on a write strobe, holds it for the decoder, and exposes the opcode and
// operand fields plus a flag showing that a word has been loaded.
module instruction_register #(
  parameter int IR_width     = 12,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             write_en,
  input  logic [IR_width-1:0]              bus_data,
  output logic [IR_width-1:0]              dataout,
  output logic [OPCODE_WIDTH-1:0]          opcode,
  output logic [IR_width-OPCODE_WIDTH-1:0] operand,
  output logic                             valid
);

  // Held word and load flag; reset beats a simultaneous load, otherwise the
  // bus word is taken bit-for-bit and held until the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout <= '0;
      valid   <= 1'b0;
    end else if (write_en) begin
      dataout <= bus_data;
      valid   <= 1'b1;
    end
  end

  // Field views are pure slices of the register, so they only move with it.
  always_comb begin
    opcode  = dataout[IR_width-1 -: OPCODE_WIDTH];
    operand = dataout[IR_width-OPCODE_WIDTH-1:0];
  end

endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard bench for instruction_register: a 12/4 instance exercises the
// default configuration and a 16/6 instance covers a wider parameter set.
module tb_instruction_register;

  typedef struct {
    bit          wide;
    logic [15:0] data;
    logic [5:0]  op;
    logic [9:0]  opr;
    logic        vld;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset_a, we_a;
  logic [11:0] bus_a;
  logic [11:0] dout_a;
  logic [3:0]  op_a;
  logic [7:0]  opr_a;
  logic        valid_a;

  logic        reset_b, we_b;
  logic [15:0] bus_b;
  logic [15:0] dout_b;
  logic [5:0]  op_b;
  logic [9:0]  opr_b;
  logic        valid_b;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  instruction_register #(.IR_width(12), .OPCODE_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset_a), .write_en(we_a), .bus_data(bus_a),
    .dataout(dout_a), .opcode(op_a), .operand(opr_a), .valid(valid_a)
  );

  instruction_register #(.IR_width(16), .OPCODE_WIDTH(6)) dut_b (
    .clk(clk), .reset(reset_b), .write_en(we_b), .bus_data(bus_b),
    .dataout(dout_b), .opcode(op_b), .operand(opr_b), .valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one edge's inputs to the selected instance and queue the result
  // expected right after that edge.
  task automatic applyStimulus(input bit wide, input logic r, input logic we,
                               input logic [15:0] data, input logic [15:0] eData,
                               input logic [5:0] eOp, input logic [9:0] eOpr,
                               input logic eVld, input string nm);
    exp_t e;
    if (wide) begin
      reset_b = r; we_b = we; bus_b = data;
    end else begin
      reset_a = r; we_a = we; bus_a = data[11:0];
    end
    @(posedge clk);
    e.wide = wide; e.data = eData; e.op = eOp; e.opr = eOpr; e.vld = eVld; e.name = nm;
    expQ.push_back(e);
    #1;
  endtask

  // Monitor: after each edge, pop the pending expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.wide) begin
          checkOutput({e.name, ".dataout"}, dout_b, e.data);
          checkOutput({e.name, ".opcode"},  {10'd0, op_b}, {10'd0, e.op});
          checkOutput({e.name, ".operand"}, {6'd0, opr_b}, {6'd0, e.opr});
          checkOutput({e.name, ".valid"},   {15'd0, valid_b}, {15'd0, e.vld});
        end else begin
          checkOutput({e.name, ".dataout"}, {4'd0, dout_a}, e.data);
          checkOutput({e.name, ".opcode"},  {12'd0, op_a}, {10'd0, e.op});
          checkOutput({e.name, ".operand"}, {8'd0, opr_a}, {6'd0, e.opr});
          checkOutput({e.name, ".valid"},   {15'd0, valid_a}, {15'd0, e.vld});
        end
      end
    end
  end

  initial begin
    int waited;
    reset_a = 1'b0; we_a = 1'bx; bus_a = 'x;
    reset_b = 1'b1; we_b = 1'b0; bus_b = '0;
    @(negedge clk);

    // 12-bit instance, expectations worked out by hand
    applyStimulus(0, 1'b1, 1'bx, 16'hxxxx, 16'h000, 6'h0, 10'h00, 1'b0, "reset");
    applyStimulus(0, 1'b0, 1'b1, 16'hFFF,  16'hFFF, 6'hF, 10'hFF, 1'b1, "load_ones");
    applyStimulus(0, 1'b1, 1'b1, 16'hC03,  16'h000, 6'h0, 10'h00, 1'b0, "reset_priority");
    applyStimulus(0, 1'b0, 1'b1, 16'hC03,  16'hC03, 6'hC, 10'h03, 1'b1, "load_c03");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1'b0, 1'b0, (i % 2 == 0) ? 16'h5A5 : 16'hA5A,
                    16'hC03, 6'hC, 10'h03, 1'b1, "hold");
    applyStimulus(0, 1'b0, 1'b1, 16'h123,  16'h123, 6'h1, 10'h23, 1'b1, "b2b_first");
    applyStimulus(0, 1'b0, 1'b1, 16'h456,  16'h456, 6'h4, 10'h56, 1'b1, "b2b_second");
    applyStimulus(0, 1'b0, 1'b1, 16'h456,  16'h456, 6'h4, 10'h56, 1'b1, "reload_same");
    applyStimulus(0, 1'b1, 1'b0, 16'h789,  16'h000, 6'h0, 10'h00, 1'b0, "reset_mid");
    applyStimulus(0, 1'b0, 1'b1, 16'h000,  16'h000, 6'h0, 10'h00, 1'b1, "load_zero");
    applyStimulus(0, 1'b0, 1'b0, 16'hABC,  16'h000, 6'h0, 10'h00, 1'b1, "hold_zero");

    // 16-bit / 6-bit opcode instance
    reset_a = 1'b0; we_a = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 6'h00, 10'h000, 1'b0, "wide_reset");
    applyStimulus(1, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 6'h2A, 10'h3CD, 1'b1, "wide_load");
    applyStimulus(1, 1'b0, 1'b0, 16'h1234, 16'hABCD, 6'h2A, 10'h3CD, 1'b1, "wide_hold");

    waited = 0;
    while (expQ.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
